// File: rtl/dow_pkg.sv
// Shared day codes, FSM encoding and wrap-around helpers for the day-of-week counter.
package dow_pkg;

    localparam logic [3:0] DAY_MON   = 4'd0;
    localparam logic [3:0] DAY_TUE   = 4'd1;
    localparam logic [3:0] DAY_WED   = 4'd2;
    localparam logic [3:0] DAY_THU   = 4'd3;
    localparam logic [3:0] DAY_FRI   = 4'd4;
    localparam logic [3:0] DAY_SAT   = 4'd5;
    localparam logic [3:0] DAY_SUN   = 4'd6;
    localparam logic [3:0] DAY_LAST  = 4'd6;
    localparam logic [3:0] DAY_BLANK = 4'hF;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } dow_state_t;

    // Out-of-range codes fold back to a legal day so day can never escape 0..6.
    function automatic logic [3:0] day_inc(input logic [3:0] d);
        return (d >= DAY_LAST) ? DAY_MON : d + 4'd1;
    endfunction

    function automatic logic [3:0] day_dec(input logic [3:0] d);
        return (d == DAY_MON || d > DAY_LAST) ? DAY_LAST : d - 4'd1;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Key rise detection plus hold-delay / repeat-rate counters; step is a one-cycle pulse.
module key_repeat #(
    parameter int DLY  = 25_000_000,
    parameter int RATE = 5_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    input  logic enable,
    input  logic clr,
    output logic step
);

    localparam int CNT_W = $clog2(((DLY > RATE) ? DLY : RATE) + 1);
    localparam logic [CNT_W-1:0] DLY_C  = CNT_W'(DLY);
    localparam logic [CNT_W-1:0] RATE_C = CNT_W'(RATE);

    logic             key_p0;
    logic [CNT_W-1:0] cnt;
    logic             rep;
    logic             armed;
    logic             rise;
    logic             held;
    logic             hit;

    assign rise = key & ~key_p0;
    assign held = key & key_p0;
    assign hit  = held & armed & (cnt == (rep ? RATE_C : DLY_C));
    assign step = enable & ~clr & (rise | hit);

    // key_p0 resets high so a key held through reset needs a fresh press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_p0 <= 1'b1;
            cnt    <= '0;
            rep    <= 1'b0;
            armed  <= 1'b0;
        end else begin
            key_p0 <= key;
            if (!enable || clr || !key) begin
                cnt   <= '0;
                rep   <= 1'b0;
                armed <= 1'b0;
            end else if (rise) begin
                cnt   <= CNT_W'(1);
                rep   <= 1'b0;
                armed <= 1'b1;
            end else if (hit) begin
                cnt <= CNT_W'(1);
                rep <= 1'b1;
            end else if (armed) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/day_of_week_counter.sv
// Day-of-week counter with RUN/SET modes, key auto-repeat and optional SET-mode blink.
// Optional blink of bcd_disp in SET mode is enabled by defining DOW_BLINK_EN.
module day_of_week_counter
    import dow_pkg::*;
#(
    parameter int BLINK_HALF  = 25_000_000,
    parameter int REPEAT_DLY  = 25_000_000,
    parameter int REPEAT_RATE = 5_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       day_tick,
    input  logic       set_key,
    input  logic       inc_key,
    input  logic       dec_key,
    output logic [3:0] day,
    output logic [3:0] bcd_disp,
    output logic       set_mode,
    output logic       week_tick
);

    dow_state_t state, state_nxt;
    logic       set_p0;
    logic       set_rise;
    logic       in_set;
    logic       both;
    logic       inc_step;
    logic       dec_step;
    logic       pend, pend_nxt;
    logic       wk_nxt;
    logic [3:0] day_nxt;
    logic [3:0] disp_nxt;

    assign set_rise = set_key & ~set_p0;
    assign in_set   = (state == SET);
    assign both     = in_set & inc_key & dec_key;

    key_repeat #(.DLY(REPEAT_DLY), .RATE(REPEAT_RATE)) u_inc (
        .clk    (clk),
        .resetn (resetn),
        .key    (inc_key),
        .enable (in_set),
        .clr    (both),
        .step   (inc_step)
    );

    key_repeat #(.DLY(REPEAT_DLY), .RATE(REPEAT_RATE)) u_dec (
        .clk    (clk),
        .resetn (resetn),
        .key    (dec_key),
        .enable (in_set),
        .clr    (both),
        .step   (dec_step)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= RUN;
            set_p0 <= 1'b1;
        end else begin
            state  <= state_nxt;
            set_p0 <= set_key;
        end
    end

    always_comb begin
        state_nxt = state;
        if (set_rise)
            state_nxt = (state == RUN) ? SET : RUN;
    end

    // A tick seen on the very cycle SET is left still counts as pending.
    always_comb begin
        day_nxt  = day;
        pend_nxt = pend;
        wk_nxt   = 1'b0;
        case (state)
            RUN: begin
                if (day_tick) begin
                    day_nxt = day_inc(day);
                    wk_nxt  = (day == DAY_LAST);
                end
            end
            SET: begin
                if (inc_step)
                    day_nxt = day_inc(day);
                else if (dec_step)
                    day_nxt = day_dec(day);
                if (day_tick)
                    pend_nxt = 1'b1;
                if (set_rise) begin
                    if (pend || day_tick) begin
                        wk_nxt  = (day_nxt == DAY_LAST);
                        day_nxt = day_inc(day_nxt);
                    end
                    pend_nxt = 1'b0;
                end
            end
            default: begin
                day_nxt = DAY_MON;
            end
        endcase
    end

`ifdef DOW_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blank, blank_nxt;

    always_comb begin
        blink_cnt_nxt = '0;
        blank_nxt     = 1'b0;
        if (state_nxt == SET) begin
            if (state == RUN || inc_step || dec_step) begin
                blink_cnt_nxt = '0;
                blank_nxt     = 1'b0;
            end else if (blink_cnt == HALF_LAST) begin
                blink_cnt_nxt = '0;
                blank_nxt     = ~blank;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
                blank_nxt     = blank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            blank     <= blank_nxt;
        end
    end

    assign disp_nxt = blank_nxt ? DAY_BLANK : day_nxt;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_HALF > 0);
    assign disp_nxt     = day_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            day       <= DAY_MON;
            pend      <= 1'b0;
            week_tick <= 1'b0;
            set_mode  <= 1'b0;
            bcd_disp  <= DAY_MON;
        end else begin
            day       <= day_nxt;
            pend      <= pend_nxt;
            week_tick <= wk_nxt;
            set_mode  <= (state_nxt == SET);
            bcd_disp  <= disp_nxt;
        end
    end

endmodule

// File: tb/tb_day_of_week_counter.sv
// Directed bench for day_of_week_counter with short blink/repeat timing.
module tb_day_of_week_counter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       day_tick;
    logic       set_key;
    logic       inc_key;
    logic       dec_key;
    logic [3:0] day;
    logic [3:0] bcd_disp;
    logic       set_mode;
    logic       week_tick;

    int checks = 0;
    int errors = 0;

    day_of_week_counter #(
        .BLINK_HALF  (5),
        .REPEAT_DLY  (8),
        .REPEAT_RATE (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .day_tick  (day_tick),
        .set_key   (set_key),
        .inc_key   (inc_key),
        .dec_key   (dec_key),
        .day       (day),
        .bcd_disp  (bcd_disp),
        .set_mode  (set_mode),
        .week_tick (week_tick)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [3:0] run_days [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
    logic [3:0] run_wk   [7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};

    initial begin
        resetn = 1'b0; day_tick = 1'b0; set_key = 1'b0; inc_key = 1'b0; dec_key = 1'b0;
        cyc(2);
        chk("rst_day", day, 4'd0);
        chk("rst_disp", bcd_disp, 4'd0);
        chk("rst_set", {3'b0, set_mode}, 4'd0);
        chk("rst_wk", {3'b0, week_tick}, 4'd0);
        resetn = 1'b1;
        cyc(1);

        // RUN: seven midnight pulses, week_tick only on the wrap
        for (int i = 0; i < 7; i++) begin
            day_tick = 1'b1; cyc(1); day_tick = 1'b0;
            chk("run_day", day, run_days[i]);
            chk("run_wk", {3'b0, week_tick}, run_wk[i]);
            cyc(1);
            chk("run_wk_low", {3'b0, week_tick}, 4'd0);
        end

        // inc ignored in RUN
        inc_key = 1'b1; cyc(1); inc_key = 1'b0; cyc(1);
        chk("run_inc_ignored", day, 4'd0);

        // enter SET, single dec then inc
        set_key = 1'b1; cyc(1); set_key = 1'b0;
        chk("set_entry", {3'b0, set_mode}, 4'd1);
        cyc(1);
        dec_key = 1'b1; cyc(1);
        chk("dec_wrap", day, 4'd6);
        chk("dec_wrap_disp", bcd_disp, 4'd6);
        chk("dec_no_wk", {3'b0, week_tick}, 4'd0);
        dec_key = 1'b0; cyc(1);
        inc_key = 1'b1; cyc(1);
        chk("inc_wrap", day, 4'd0);
        chk("inc_no_wk", {3'b0, week_tick}, 4'd0);
        inc_key = 1'b0; cyc(1);

        // auto-repeat: press plus steps at +8, +12, +16, +20
        inc_key = 1'b1; cyc(1);
        chk("rep_press", day, 4'd1);
        cyc(7);
        chk("rep_e7", day, 4'd1);
        cyc(1);
        chk("rep_e8", day, 4'd2);
        cyc(3);
        chk("rep_e11", day, 4'd2);
        cyc(1);
        chk("rep_e12", day, 4'd3);
        cyc(4);
        chk("rep_e16", day, 4'd4);
        cyc(4);
        chk("rep_e20", day, 4'd5);
        inc_key = 1'b0; cyc(3);
        chk("rep_release", day, 4'd5);

        // inc and dec together: no step, no repeat
        inc_key = 1'b1; dec_key = 1'b1; cyc(1);
        chk("both_press", day, 4'd5);
        cyc(12);
        chk("both_held", day, 4'd5);
        inc_key = 1'b0; dec_key = 1'b0; cyc(1);

        // pending ticks collapse; applied on leaving SET
        inc_key = 1'b1; cyc(1); inc_key = 1'b0; cyc(1);
        chk("to_sun", day, 4'd6);
        for (int i = 0; i < 3; i++) begin
            day_tick = 1'b1; cyc(1); day_tick = 1'b0; cyc(1);
        end
        chk("set_tick_held", day, 4'd6);
        set_key = 1'b1; cyc(1); set_key = 1'b0;
        chk("exit_mode", {3'b0, set_mode}, 4'd0);
        chk("exit_day", day, 4'd0);
        chk("exit_wk", {3'b0, week_tick}, 4'd1);
        cyc(1);
        chk("exit_wk_low", {3'b0, week_tick}, 4'd0);
        chk("exit_day_hold", day, 4'd0);

        // RUN tick together with set rise: advance, then SET
        day_tick = 1'b1; set_key = 1'b1; cyc(1); day_tick = 1'b0; set_key = 1'b0;
        chk("tick_set_day", day, 4'd1);
        chk("tick_set_mode", {3'b0, set_mode}, 4'd1);
        cyc(1);
        set_key = 1'b1; cyc(1); set_key = 1'b0;
        chk("no_pend_exit", day, 4'd1);
        chk("no_pend_mode", {3'b0, set_mode}, 4'd0);
        cyc(1);

        // blink phase in SET at day 3
        for (int i = 0; i < 2; i++) begin
            day_tick = 1'b1; cyc(1); day_tick = 1'b0; cyc(1);
        end
        chk("pre_blink_day", day, 4'd3);
        set_key = 1'b1; cyc(1); set_key = 1'b0;
        chk("blink_e0", bcd_disp, 4'd3);
        cyc(4);
        chk("blink_e4", bcd_disp, 4'd3);
        cyc(1);
`ifdef DOW_BLINK_EN
        chk("blink_e5", bcd_disp, 4'hF);
`else
        chk("blink_e5", bcd_disp, 4'd3);
`endif
        cyc(1);
        inc_key = 1'b1; cyc(1);
        chk("blink_inc_disp", bcd_disp, 4'd4);
        chk("blink_inc_day", day, 4'd4);
        inc_key = 1'b0; cyc(1);

        // reset in SET with inc held; held key must not step afterwards
        inc_key = 1'b1; cyc(1);
        chk("pre_rst_day", day, 4'd5);
        cyc(3);
        resetn = 1'b0; cyc(1);
        chk("mid_rst_day", day, 4'd0);
        chk("mid_rst_mode", {3'b0, set_mode}, 4'd0);
        chk("mid_rst_disp", bcd_disp, 4'd0);
        resetn = 1'b1; cyc(12);
        chk("post_rst_held", day, 4'd0);
        set_key = 1'b1; cyc(1); set_key = 1'b0;
        chk("post_rst_set", {3'b0, set_mode}, 4'd1);
        cyc(12);
        chk("held_into_set", day, 4'd0);
        inc_key = 1'b0; cyc(1);
        inc_key = 1'b1; cyc(1);
        chk("repress", day, 4'd1);
        inc_key = 1'b0; cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
